// File: rtl/interval_meter_pkg.sv
// Shared types for the interval meter: FSM state encoding and the default counter width.
package interval_meter_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/interval_meter_fsm.sv
// Measurement sequencer: start/stop are same-cycle decodes of evt, busy is registered (MEASURE).
// HOLD waits for the result handshake; INTERVAL_METER_AUTORESTART_EN keeps it in MEASURE on stop.
module interval_meter_fsm
  import interval_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic evt,
  input  logic valid,
  input  logic ready,
  output logic busy,
  output logic start,
  output logic stop
);

  state_t state;

  assign start = (state == IDLE) && evt;
  assign stop  = (state == MEASURE) && evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (evt) begin
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (evt) begin
`ifdef INTERVAL_METER_AUTORESTART_EN
            state <= MEASURE;
            busy  <= 1'b1;
`else
            state <= HOLD;
            busy  <= 1'b0;
`endif
          end
        end
        HOLD: begin
          // Events are ignored here; only consumption of the result moves on.
          if (valid && ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/interval_meter.sv
// Counts enabled cycles between two evt pulses; result appears 1 cycle after the stop event.
// value/overflow held stable while valid=1 until ready; INTERVAL_METER_AUTORESTART_EN adds restart + dropped.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             evt,
  input  logic             ready,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             overflow,
  output logic             busy
`ifdef INTERVAL_METER_AUTORESTART_EN
  ,
  output logic             dropped
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  logic             start;
  logic             stop;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] cnt;
  logic             sat;

  interval_meter_fsm u_fsm (
    .clk   (clk),
    .reset (reset),
    .evt   (evt),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .start (start),
    .stop  (stop)
  );

  assign accept = valid && ready;
  // A new result may only overwrite the output register once the old one is gone.
  assign load   = stop && (!valid || ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (start || stop) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (busy && enable && !sat) begin
      cnt <= cnt + CNT_ONE;
      if (cnt == CNT_LAST) begin
        sat <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else if (load) begin
      value    <= cnt;
      overflow <= sat;
      valid    <= 1'b1;
    end else if (accept) begin
      valid    <= 1'b0;
    end
  end

`ifdef INTERVAL_METER_AUTORESTART_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dropped <= 1'b0;
    end else if (stop && valid && !ready) begin
      dropped <= 1'b1;
    end
  end
`endif

endmodule
